// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the MEM-stage load/store unit.
// Holds the FSM state enum, the funct3 access-size codes and the legality check.
// Contents: state_t, F3_* codes, access_legal().
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // An access is legal when funct3 is a known size and the address is
    // naturally aligned for that size.
    function automatic logic access_legal(input logic [2:0] f3, input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B, F3_BU: ok = 1'b1;
            F3_H, F3_HU: ok = (addr_lo[0] == 1'b0);
            F3_W:        ok = (addr_lo == 2'b00);
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_extend.sv
// load_extend: selects the addressed byte/half lane of a read word and sign/zero-extends it.
// Latency: purely combinational. Backpressure: none.
// Ports: dm_rdata (read word), addr_lo (byte offset), funct3 (size/sign), ext_data (result).
module load_extend
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] dm_rdata,
    input  logic [1:0]        addr_lo,
    input  logic [2:0]        funct3,
    output logic [DATA_W-1:0] ext_data
);

    // Shift the addressed lane down to bit 0 so every size extracts from [7:0]/[15:0].
    logic [DATA_W-1:0] w_shifted;
    assign w_shifted = dm_rdata >> {addr_lo, 3'b000};

    always_comb begin
        ext_data = w_shifted;
        case (funct3)
            F3_B:    ext_data = {{(DATA_W-8){w_shifted[7]}}, w_shifted[7:0]};
            F3_BU:   ext_data = {{(DATA_W-8){1'b0}}, w_shifted[7:0]};
            F3_H:    ext_data = {{(DATA_W-16){w_shifted[15]}}, w_shifted[15:0]};
            F3_HU:   ext_data = {{(DATA_W-16){1'b0}}, w_shifted[15:0]};
            default: ext_data = dm_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage engine turning load/store control into word-aligned memory requests.
// Latency: request cycle + >=1 WAIT cycle until dm_ack, result/rd_valid in the following DONE cycle.
// Backpressure: stall held combinationally from the request cycle until dm_ack; misaligned ops never stall.
// Ports: pipeline side (mem_read/mem_write/funct3/addr/wr_data -> stall/rd_data/rd_valid/misalign),
//        memory side (dm_req/dm_we/dm_addr/dm_be/dm_wdata -> dm_ack/dm_rdata).
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [2:0]          funct3,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wr_data,
    output logic                stall,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                misalign,
    output logic                dm_req,
    output logic                dm_we,
    output logic [ADDR_W-3:0]   dm_addr,
    output logic [DATA_W/8-1:0] dm_be,
    output logic [DATA_W-1:0]   dm_wdata,
    input  logic                dm_ack,
    input  logic [DATA_W-1:0]   dm_rdata
);

    localparam int BE_W = DATA_W / 8;

    state_t            r_state;
    logic              r_is_load;
    logic [1:0]        r_addr_lo;
    logic [2:0]        r_funct3;

    logic              w_req;
    logic              w_legal;
    logic [BE_W-1:0]   w_be;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_ext;

    assign w_req   = mem_read | mem_write;
    assign w_legal = access_legal(funct3, addr[1:0]);
    assign stall   = ((r_state == IDLE) && w_req && w_legal) || (r_state == WAIT);

    // Size is encoded in funct3[1:0]; the sign bit funct3[2] does not matter for stores.
    always_comb begin
        w_be    = {BE_W{1'b1}};
        w_wdata = wr_data;
        case (funct3[1:0])
            2'b00: begin
                w_be    = BE_W'(1) << addr[1:0];
                w_wdata = {(DATA_W/8){wr_data[7:0]}};
            end
            2'b01: begin
                w_be    = addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {(DATA_W/16){wr_data[15:0]}};
            end
            default: begin
                w_be    = {BE_W{1'b1}};
                w_wdata = wr_data;
            end
        endcase
    end

    // Extraction uses the latched offset/size so it does not depend on the pipeline holding addr.
    load_extend #(.DATA_W(DATA_W)) u_load_extend (
        .dm_rdata (dm_rdata),
        .addr_lo  (r_addr_lo),
        .funct3   (r_funct3),
        .ext_data (w_ext)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_is_load <= 1'b0;
            r_addr_lo <= '0;
            r_funct3  <= '0;
            dm_req    <= 1'b0;
            dm_we     <= 1'b0;
            dm_addr   <= '0;
            dm_be     <= '0;
            dm_wdata  <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            misalign  <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            misalign <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req && w_legal) begin
                        // A simultaneous read+write is a store.
                        r_is_load <= ~mem_write;
                        r_addr_lo <= addr[1:0];
                        r_funct3  <= funct3;
                        dm_req    <= 1'b1;
                        dm_we     <= mem_write;
                        dm_addr   <= addr[ADDR_W-1:2];
                        dm_be     <= w_be;
                        dm_wdata  <= w_wdata;
                        r_state   <= WAIT;
                    end else if (w_req) begin
                        misalign <= 1'b1;
                    end
                end
                WAIT: begin
                    if (dm_ack) begin
                        dm_req <= 1'b0;
                        if (r_is_load) begin
                            rd_data  <= w_ext;
                            rd_valid <= 1'b1;
                        end
                        r_state <= DONE;
                    end
                end
                // The MEM instruction advances here; any request still visible belongs to it.
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench for load_store_unit.
// Inputs change 1ns after a rising edge; outputs are sampled there or at the falling edge.
// Expected values are hand-computed constants.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [8:0]  addr;
    logic [31:0] wr_data;
    logic        stall;
    logic [31:0] rd_data;
    logic        rd_valid, misalign;
    logic        dm_req, dm_we;
    logic [6:0]  dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    int n_pass = 0;
    int n_total = 0;

    // Falling-edge activity counters.
    int stall_cnt = 0;
    int req_cnt   = 0;

    // Values captured during an access.
    logic        cap_req, cap_we, done_rv, done_stall, done_req;
    logic [6:0]  cap_addr;
    logic [3:0]  cap_be;
    logic [31:0] cap_wdata;
    int          stall_base, req_base;

    load_store_unit #(.DATA_W(32), .ADDR_W(9)) dut (
        .clk      (clk),
        .reset    (reset),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .funct3   (funct3),
        .addr     (addr),
        .wr_data  (wr_data),
        .stall    (stall),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .misalign (misalign),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_be    (dm_be),
        .dm_wdata (dm_wdata),
        .dm_ack   (dm_ack),
        .dm_rdata (dm_rdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (stall)  stall_cnt = stall_cnt + 1;
        if (dm_req) req_cnt   = req_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issues one access, acks it in WAIT cycle nwait, and returns one cycle after DONE.
    task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [8:0] a, input logic [31:0] wd,
                          input int nwait, input logic [31:0] rdata);
        stall_base = stall_cnt;
        req_base   = req_cnt;
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wr_data = wd;
        tick();
        mem_read = 1'b0; mem_write = 1'b0;
        cap_req = dm_req; cap_we = dm_we; cap_addr = dm_addr;
        cap_be = dm_be; cap_wdata = dm_wdata;
        for (int i = 1; i < nwait; i++) tick();
        dm_ack = 1'b1; dm_rdata = rdata;
        tick();
        dm_ack = 1'b0; dm_rdata = 32'h0;
        done_rv = rd_valid; done_stall = stall; done_req = dm_req;
        tick();
    endtask

    initial begin
        reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
        addr = '0; wr_data = '0; dm_ack = 1'b0; dm_rdata = '0;
        tick(); tick();
        check("rst_dm_req",   {31'b0, dm_req},   32'h0);
        check("rst_rd_valid", {31'b0, rd_valid}, 32'h0);
        check("rst_misalign", {31'b0, misalign}, 32'h0);
        check("rst_dm_be",    {28'b0, dm_be},    32'h0);
        check("rst_dm_wdata", dm_wdata,          32'h0);
        check("rst_rd_data",  rd_data,           32'h0);
        reset = 1'b0;
        tick();

        // LW, ack in third WAIT cycle.
        run_op(1'b1, 1'b0, 3'b010, 9'h00C, 32'h0, 3, 32'hDEADBEEF);
        check("lw_req",     {31'b0, cap_req},  32'h1);
        check("lw_we",      {31'b0, cap_we},   32'h0);
        check("lw_addr",    {25'b0, cap_addr}, 32'h3);
        check("lw_be",      {28'b0, cap_be},   32'hF);
        check("lw_stall",   stall_cnt - stall_base, 4);
        check("lw_rv",      {31'b0, done_rv},  32'h1);
        check("lw_done_st", {31'b0, done_stall}, 32'h0);
        check("lw_req_off", {31'b0, done_req}, 32'h0);
        check("lw_data",    rd_data,           32'hDEADBEEF);

        // LB / LBU at lane 3, minimum latency.
        run_op(1'b1, 1'b0, 3'b000, 9'h003, 32'h0, 1, 32'h80112233);
        check("lb_be",    {28'b0, cap_be}, 32'h8);
        check("lb_stall", stall_cnt - stall_base, 2);
        check("lb_data",  rd_data, 32'hFFFFFF80);
        run_op(1'b1, 1'b0, 3'b100, 9'h003, 32'h0, 1, 32'h80112233);
        check("lbu_data", rd_data, 32'h00000080);

        // LH upper half, then LH lower half negative.
        run_op(1'b1, 1'b0, 3'b001, 9'h002, 32'h0, 1, 32'h7FFF0000);
        check("lh_be",   {28'b0, cap_be}, 32'hC);
        check("lh_data", rd_data, 32'h00007FFF);
        run_op(1'b1, 1'b0, 3'b001, 9'h000, 32'h0, 2, 32'h12348001);
        check("lh0_be",   {28'b0, cap_be}, 32'h3);
        check("lh0_data", rd_data, 32'hFFFF8001);
        run_op(1'b1, 1'b0, 3'b101, 9'h000, 32'h0, 1, 32'h12348001);
        check("lhu_data", rd_data, 32'h00008001);

        // SB at byte 1 of word 1.
        run_op(1'b0, 1'b1, 3'b000, 9'h005, 32'h000000AB, 2, 32'h55555555);
        check("sb_we",    {31'b0, cap_we},   32'h1);
        check("sb_addr",  {25'b0, cap_addr}, 32'h1);
        check("sb_be",    {28'b0, cap_be},   32'h2);
        check("sb_wdata", cap_wdata,         32'hABABABAB);
        check("sb_rv",    {31'b0, done_rv},  32'h0);
        check("sb_keep",  rd_data,           32'h00008001);

        // SH to upper half, with read+write both high (store wins).
        run_op(1'b1, 1'b1, 3'b001, 9'h00A, 32'hCAFE1234, 1, 32'h0);
        check("sh_we",    {31'b0, cap_we}, 32'h1);
        check("sh_be",    {28'b0, cap_be}, 32'hC);
        check("sh_wdata", cap_wdata,       32'h12341234);
        check("sh_keep",  rd_data,         32'h00008001);

        // Misaligned LW: pulse only, no stall, no request.
        stall_base = stall_cnt; req_base = req_cnt;
        mem_read = 1'b1; funct3 = 3'b010; addr = 9'h006;
        #1;
        check("mis_stall0", {31'b0, stall}, 32'h0);
        tick();
        mem_read = 1'b0;
        check("mis_pulse", {31'b0, misalign}, 32'h1);
        tick();
        check("mis_clear", {31'b0, misalign}, 32'h0);
        // Reserved funct3 is rejected too.
        mem_read = 1'b1; funct3 = 3'b011; addr = 9'h000;
        tick();
        mem_read = 1'b0;
        check("bad_f3", {31'b0, misalign}, 32'h1);
        tick();
        check("mis_no_stall", stall_cnt - stall_base, 0);
        check("mis_no_req",   req_cnt - req_base, 0);

        // Reset during WAIT, then a stray ack.
        mem_read = 1'b1; funct3 = 3'b010; addr = 9'h010;
        tick();
        mem_read = 1'b0;
        check("rw_req", {31'b0, dm_req}, 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        dm_ack = 1'b1; dm_rdata = 32'h11111111;
        check("rw_req_off", {31'b0, dm_req}, 32'h0);
        check("rw_rd_data", rd_data, 32'h0);
        tick();
        dm_ack = 1'b0;
        check("rw_rv",    {31'b0, rd_valid}, 32'h0);
        check("rw_req2",  {31'b0, dm_req},   32'h0);
        check("rw_stall", {31'b0, stall},    32'h0);
        check("rw_data2", rd_data,           32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
